// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for the sequential ALU. The master
//                side issues operations (in_valid, SrcA, SrcB, Operation,
//                flush) and observes in_ready, out_valid and ALUResult.
//  Signals     : in_valid   - operation request is valid
//                in_ready   - ALU can accept a request
//                SrcA/SrcB  - operands, DATA_WIDTH bits
//                Operation  - opcode, OPCODE_LENGTH bits
//                flush      - abort any in-flight operation
//                out_valid  - one-cycle pulse marking ALUResult valid
//                ALUResult  - registered result, DATA_WIDTH bits
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     flush;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    ALUResult;

    modport master (
        output in_valid,
        output SrcA,
        output SrcB,
        output Operation,
        output flush,
        input  in_ready,
        input  out_valid,
        input  ALUResult
    );

    modport slave (
        input  in_valid,
        input  SrcA,
        input  SrcB,
        input  Operation,
        input  flush,
        output in_ready,
        output out_valid,
        output ALUResult
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU. Logic/arithmetic/shift/compare opcodes
//                finish one cycle after acceptance; MUL/MULHU (and DIVU/REMU
//                when ALU_SEQ_DIV_EN is defined) run an iterative radix-2
//                datapath for DATA_WIDTH cycles in the BUSY state.
//  Macro       : ALU_SEQ_DIV_EN - when defined, builds the restoring
//                divider for DIVU/REMU; otherwise those opcodes behave as
//                undefined opcodes (single cycle, result 0).
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-low reset
//                bus   - alu_seq_if slave modport (request/response)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  wire logic  clk,
    input  wire logic  reset,
    alu_seq_if.slave   bus
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam int CW  = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] c_LAST_ITER = CW'(DATA_WIDTH - 1);

    localparam logic [OPCODE_LENGTH-1:0] c_OP_AND   = OPCODE_LENGTH'(5'b00000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_OR    = OPCODE_LENGTH'(5'b00001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD   = OPCODE_LENGTH'(5'b00010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SUB   = OPCODE_LENGTH'(5'b00011);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_XOR   = OPCODE_LENGTH'(5'b00100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLL   = OPCODE_LENGTH'(5'b00101);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRL   = OPCODE_LENGTH'(5'b00110);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SRA   = OPCODE_LENGTH'(5'b00111);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_EQ    = OPCODE_LENGTH'(5'b01000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLT   = OPCODE_LENGTH'(5'b01001);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_SLTU  = OPCODE_LENGTH'(5'b01010);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_MUL   = OPCODE_LENGTH'(5'b10000);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_MULHU = OPCODE_LENGTH'(5'b10001);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [OPCODE_LENGTH-1:0] c_OP_DIVU  = OPCODE_LENGTH'(5'b10100);
    localparam logic [OPCODE_LENGTH-1:0] c_OP_REMU  = OPCODE_LENGTH'(5'b10101);
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [CW-1:0]           cnt_q;
    // Shared working register: {high, low} product for multiply,
    // {remainder, quotient} for divide.
    logic [2*DATA_WIDTH-1:0] work_q;
    logic [DATA_WIDTH-1:0]   opb_q;
    // Opcode bit 0 selects the high half (MULHU/REMU) of the working register.
    logic                    hi_q;
`ifdef ALU_SEQ_DIV_EN
    logic                    div_q;
`endif

    // ------------------------------------------------------------------
    // Single-cycle result
    // ------------------------------------------------------------------
    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_alu_res;
    logic                  w_is_multi;
    logic                  w_is_div;

    assign w_shamt = bus.SrcB[SHW-1:0];

    always_comb begin
        w_alu_res = '0;
        case (bus.Operation)
            c_OP_AND:  w_alu_res = bus.SrcA & bus.SrcB;
            c_OP_OR:   w_alu_res = bus.SrcA | bus.SrcB;
            c_OP_ADD:  w_alu_res = bus.SrcA + bus.SrcB;
            c_OP_SUB:  w_alu_res = bus.SrcA - bus.SrcB;
            c_OP_XOR:  w_alu_res = bus.SrcA ^ bus.SrcB;
            c_OP_SLL:  w_alu_res = bus.SrcA << w_shamt;
            c_OP_SRL:  w_alu_res = bus.SrcA >> w_shamt;
            c_OP_SRA:  w_alu_res = $unsigned($signed(bus.SrcA) >>> w_shamt);
            c_OP_EQ:   w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (bus.SrcA == bus.SrcB)};
            c_OP_SLT:  w_alu_res = {{(DATA_WIDTH-1){1'b0}},
                                    ($signed(bus.SrcA) < $signed(bus.SrcB))};
            c_OP_SLTU: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            default:   w_alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    assign w_is_div = (bus.Operation == c_OP_DIVU) || (bus.Operation == c_OP_REMU);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_is_multi = (bus.Operation == c_OP_MUL) || (bus.Operation == c_OP_MULHU) || w_is_div;

    // ------------------------------------------------------------------
    // Radix-2 multiply step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole register right.
    // After DATA_WIDTH steps the register holds the full product.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [2*DATA_WIDTH-1:0] w_mul_next;
    logic [2*DATA_WIDTH-1:0] w_work_next;

    assign w_mul_sum  = {1'b0, work_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                      + (work_q[0] ? {1'b0, opb_q} : {(DATA_WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, work_q[DATA_WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // Restoring division step: shift the next dividend bit into the
    // remainder and subtract the divisor if it fits. A zero divisor always
    // fits, which yields an all-ones quotient and remainder == dividend.
    logic [DATA_WIDTH:0]     w_div_shift;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic [2*DATA_WIDTH-1:0] w_div_next;

    assign w_div_shift = {work_q[2*DATA_WIDTH-1:DATA_WIDTH], work_q[DATA_WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, opb_q};
    assign w_div_next  = w_div_diff[DATA_WIDTH]
                       ? {w_div_shift[DATA_WIDTH-1:0], work_q[DATA_WIDTH-2:0], 1'b0}
                       : {w_div_diff[DATA_WIDTH-1:0],  work_q[DATA_WIDTH-2:0], 1'b1};
    assign w_work_next = div_q ? w_div_next : w_mul_next;
`else
    assign w_work_next = w_mul_next;
`endif

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cnt_q       <= '0;
            work_q      <= '0;
            opb_q       <= '0;
            hi_q        <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // flush drops a request presented in the same cycle
                    if (bus.in_valid && !bus.flush) begin
                        if (w_is_multi) begin
                            state_q    <= BUSY;
                            in_ready_q <= 1'b0;
                            work_q     <= {{DATA_WIDTH{1'b0}}, bus.SrcA};
                            opb_q      <= bus.SrcB;
                            cnt_q      <= '0;
                            hi_q       <= bus.Operation[0];
`ifdef ALU_SEQ_DIV_EN
                            div_q      <= w_is_div;
`endif
                        end else begin
                            result_q    <= w_alu_res;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        work_q <= w_work_next;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == c_LAST_ITER) begin
                            state_q     <= IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            result_q    <= hi_q ? w_work_next[2*DATA_WIDTH-1:DATA_WIDTH]
                                                : w_work_next[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;

endmodule
`default_nettype wire
